// File: rtl/sprite_pixel_sched_if.sv
// Shared sprite-ROM / palette bus between the pixel scheduler (master)
// and the ROM + palette lookup (slave).
interface sprite_pixel_sched_if #(
    parameter int ROM_AW = 12
);
    logic [ROM_AW-1:0] rom_addr;
    logic [3:0]        rom_data;
    logic [3:0]        pal_index;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;

    modport master (
        output rom_addr, pal_index,
        input  rom_data, pal_red, pal_green, pal_blue
    );
    modport slave (
        input  rom_addr, pal_index,
        output rom_data, pal_red, pal_green, pal_blue
    );
endinterface

// File: rtl/sprite_pixel_sched.sv
// Per-pixel sprite scheduler: hit-tests frame-latched sprite positions,
// picks the lowest-id winner, fetches its ROM texel and emits registered RGB.
module sprite_hit_lane #(
    parameter int W_LOG2 = 5,
    parameter int H_LOG2 = 5
) (
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    input  logic              en,
    output logic              hit,
    output logic [W_LOG2-1:0] dx,
    output logic [H_LOG2-1:0] dy
);
    logic [10:0] x_end, y_end;

    // 11-bit bounds so a sprite hanging past column/row 1023 never wraps to 0
    assign x_end = {1'b0, sx} + 11'(1 << W_LOG2);
    assign y_end = {1'b0, sy} + 11'(1 << H_LOG2);
    assign hit   = en && (px >= sx) && ({1'b0, px} < x_end)
                      && (py >= sy) && ({1'b0, py} < y_end);
    assign dx    = W_LOG2'(px - sx);
    assign dy    = H_LOG2'(py - sy);
endmodule

module sprite_pixel_sched #(
    parameter int NUM_SPR    = 4,
    parameter int SPR_W_LOG2 = 5,
    parameter int SPR_H_LOG2 = 5,
    parameter int TRANSP_IDX = 0,
    localparam int ROM_AW    = $clog2(NUM_SPR) + SPR_H_LOG2 + SPR_W_LOG2
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [NUM_SPR*10-1:0]   spr_x,
    input  logic [NUM_SPR*10-1:0]   spr_y,
    input  logic [NUM_SPR-1:0]      spr_en,
    input  logic [11:0]             bg_rgb,
    sprite_pixel_sched_if.master    mem,
    output logic [11:0]             rgb_out,
    output logic                    rgb_valid,
    output logic [2:0]              hit_id,
    output logic                    hit
);
    localparam logic [3:0] TRANSP = 4'(TRANSP_IDX);

    typedef struct packed {
        logic        vld;
        logic        hit;
        logic [2:0]  id;
        logic [11:0] bg;
    } side_t;

    logic [NUM_SPR-1:0][9:0]            sx_q, sx_d, sy_q, sy_d;
    logic [NUM_SPR-1:0]                 en_q, en_d;
    logic [NUM_SPR-1:0]                 lane_hit;
    logic [NUM_SPR-1:0][SPR_W_LOG2-1:0] lane_dx;
    logic [NUM_SPR-1:0][SPR_H_LOG2-1:0] lane_dy;

    logic                  win;
    logic [2:0]            win_id;
    logic [SPR_W_LOG2-1:0] win_dx;
    logic [SPR_H_LOG2-1:0] win_dy;

    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    side_t             s0_q, s0_d, s1_q, s1_d;
    logic [11:0]       rgb_q, rgb_d;
    logic              rgb_valid_q, rgb_valid_d;
    logic              hit_q, hit_d;
    logic [2:0]        hit_id_q, hit_id_d;

    // Shadow copy refreshed only at frame_start; a pixel on the same edge sees the old copy
    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        en_d = en_q;
        if (frame_start) begin
            sx_d = spr_x;
            sy_d = spr_y;
            en_d = spr_en;
        end
    end

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_lane
        sprite_hit_lane #(.W_LOG2(SPR_W_LOG2), .H_LOG2(SPR_H_LOG2)) u_lane (
            .px  (DrawX),
            .py  (DrawY),
            .sx  (sx_q[i]),
            .sy  (sy_q[i]),
            .en  (en_q[i]),
            .hit (lane_hit[i]),
            .dx  (lane_dx[i]),
            .dy  (lane_dy[i])
        );
    end

    // Descending scan so the lowest hitting id is the last one written
    always_comb begin
        win    = 1'b0;
        win_id = '0;
        win_dx = '0;
        win_dy = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (lane_hit[i]) begin
                win    = 1'b1;
                win_id = 3'(i);
                win_dx = lane_dx[i];
                win_dy = lane_dy[i];
            end
        end
    end

    always_comb begin
        rom_addr_d = rom_addr_q;
        if (pix_valid && win)
            rom_addr_d = ROM_AW'({win_id, win_dy, win_dx});
        s0_d.vld = pix_valid;
        s0_d.hit = pix_valid && win;
        s0_d.id  = win_id;
        s0_d.bg  = bg_rgb;
        s1_d     = s0_q;
    end

    // A transparent winner shows background; lower-priority sprites are not consulted
    always_comb begin
        rgb_valid_d = s1_q.vld;
        rgb_d       = '0;
        hit_d       = 1'b0;
        hit_id_d    = '0;
        if (s1_q.vld) begin
            if (s1_q.hit && (mem.rom_data != TRANSP)) begin
                rgb_d    = {mem.pal_red, mem.pal_green, mem.pal_blue};
                hit_d    = 1'b1;
                hit_id_d = s1_q.id;
            end else begin
                rgb_d = s1_q.bg;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_q        <= '0;
            sy_q        <= '0;
            en_q        <= '0;
            rom_addr_q  <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_id_q    <= '0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            en_q        <= en_d;
            rom_addr_q  <= rom_addr_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= rgb_valid_d;
            hit_q       <= hit_d;
            hit_id_q    <= hit_id_d;
        end
    end

    assign mem.rom_addr  = rom_addr_q;
    assign mem.pal_index = mem.rom_data;
    assign rgb_out       = rgb_q;
    assign rgb_valid     = rgb_valid_q;
    assign hit           = hit_q;
    assign hit_id        = hit_id_q;
endmodule

// File: tb/tb_sprite_pixel_sched.sv
// Directed bench: synchronous ROM model plus a palette of {i, ~i, i^A}.
module tb_sprite_pixel_sched;
    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start, pix_valid;
    logic [9:0]  DrawX, DrawY;
    logic [39:0] spr_x, spr_y;
    logic [3:0]  spr_en;
    logic [11:0] bg_rgb;
    logic [11:0] rgb_out;
    logic        rgb_valid, hit;
    logic [2:0]  hit_id;

    int total = 0;
    int bad   = 0;

    logic [3:0] rom_mem [4096];

    sprite_pixel_sched_if #(.ROM_AW(12)) mif ();

    sprite_pixel_sched dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_en      (spr_en),
        .bg_rgb      (bg_rgb),
        .mem         (mif),
        .rgb_out     (rgb_out),
        .rgb_valid   (rgb_valid),
        .hit_id      (hit_id),
        .hit         (hit)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) mif.rom_data <= rom_mem[mif.rom_addr];
    assign mif.pal_red   = mif.pal_index;
    assign mif.pal_green = ~mif.pal_index;
    assign mif.pal_blue  = mif.pal_index ^ 4'hA;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_frame();
        @(negedge Clk) frame_start = 1'b1;
        @(posedge Clk);
        #1 frame_start = 1'b0;
    endtask

    // One isolated pixel: address after edge k, palette index after k+1, output after k+2.
    // bg_rgb is disturbed after edge k so the output must use the copy taken at edge k.
    task automatic px(input string tag, input logic [9:0] x, input logic [9:0] y,
                      input logic v, input logic fs, input logic [11:0] exp_addr,
                      input logic [11:0] exp_rgb, input logic exp_hit, input logic [2:0] exp_id);
        @(negedge Clk);
        DrawX = x; DrawY = y; pix_valid = v; frame_start = fs;
        @(posedge Clk);
        #1 chk({tag, ".addr"}, 32'(mif.rom_addr), 32'(exp_addr));
        @(negedge Clk);
        pix_valid = 1'b0; frame_start = 1'b0; bg_rgb = 12'h111;
        @(posedge Clk);
        #1 chk({tag, ".pal"}, 32'(mif.pal_index), 32'(rom_mem[exp_addr]));
        @(posedge Clk);
        #1;
        chk({tag, ".vld"}, 32'(rgb_valid), 32'(v));
        chk({tag, ".rgb"}, 32'(rgb_out), 32'(exp_rgb));
        chk({tag, ".hit"}, 32'(hit), 32'(exp_hit));
        chk({tag, ".id"},  32'(hit_id), 32'(exp_id));
        @(negedge Clk) bg_rgb = 12'hB83;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) rom_mem[a] = 4'h1;
        rom_mem[12'h000] = 4'h7;
        rom_mem[12'h465] = 4'h0;
        rom_mem[12'h865] = 4'h9;
        mif.rom_data = 4'h0;
        Reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        DrawX = '0; DrawY = '0; spr_x = '0; spr_y = '0; spr_en = '0;
        bg_rgb = 12'hB83;
        repeat (2) @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b1;

        // Stream pixels on sprite 0 at (0,0), then reset asynchronously mid-stream
        spr_en = 4'b0001;
        load_frame();
        @(negedge Clk);
        DrawX = 10'd1; DrawY = 10'd1; pix_valid = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b0;
        #1;
        chk("rst.addr", 32'(mif.rom_addr), 32'd0);
        chk("rst.rgb",  32'(rgb_out), 32'd0);
        chk("rst.vld",  32'(rgb_valid), 32'd0);
        chk("rst.hit",  32'(hit), 32'd0);
        chk("rst.id",   32'(hit_id), 32'd0);
        @(negedge Clk) Reset_n = 1'b1;
        @(posedge Clk); #1 chk("rv.e1", 32'(rgb_valid), 32'd0);
        @(posedge Clk); #1 chk("rv.e2", 32'(rgb_valid), 32'd0);
        @(posedge Clk); #1 chk("rv.e3", 32'(rgb_valid), 32'd1);
        chk("rv.hit", 32'(hit), 32'd0);
        chk("rv.rgb", 32'(rgb_out), 32'hB83);
        @(negedge Clk) pix_valid = 1'b0;
        repeat (3) @(posedge Clk);

        // Sprite 0 at (100,50)
        spr_x[9:0] = 10'd100; spr_y[9:0] = 10'd50; spr_en = 4'b0001;
        load_frame();
        px("s0_org",  10'd100, 10'd50, 1'b1, 1'b0, 12'h000, 12'h78D, 1'b1, 3'd0);
        px("s0_far",  10'd131, 10'd81, 1'b1, 1'b0, 12'h3FF, 12'h1EB, 1'b1, 3'd0);
        px("s0_rgt",  10'd132, 10'd50, 1'b1, 1'b0, 12'h3FF, 12'hB83, 1'b0, 3'd0);
        px("s0_lft",  10'd99,  10'd50, 1'b1, 1'b0, 12'h3FF, 12'hB83, 1'b0, 3'd0);

        // Sprites 1 and 2 overlap at (200,200)
        spr_x[19:10] = 10'd200; spr_y[19:10] = 10'd200;
        spr_x[29:20] = 10'd200; spr_y[29:20] = 10'd200;
        spr_en = 4'b0111;
        load_frame();
        px("ovl_tr",  10'd205, 10'd203, 1'b1, 1'b0, 12'h465, 12'hB83, 1'b0, 3'd0);
        px("ovl_op",  10'd206, 10'd203, 1'b1, 1'b0, 12'h466, 12'h1EB, 1'b1, 3'd1);

        // Mid-frame position change is invisible until frame_start
        spr_x[9:0] = 10'd300;
        px("tear_old", 10'd100, 10'd50, 1'b1, 1'b0, 12'h000, 12'h78D, 1'b1, 3'd0);
        load_frame();
        px("tear_gone", 10'd100, 10'd50, 1'b1, 1'b0, 12'h000, 12'hB83, 1'b0, 3'd0);
        px("tear_new",  10'd300, 10'd50, 1'b1, 1'b0, 12'h000, 12'h78D, 1'b1, 3'd0);

        // Pixel on the frame_start edge still uses the previous shadow
        spr_x[9:0] = 10'd500;
        px("fs_same", 10'd300, 10'd50, 1'b1, 1'b1, 12'h000, 12'h78D, 1'b1, 3'd0);
        px("fs_after", 10'd300, 10'd50, 1'b1, 1'b0, 12'h000, 12'hB83, 1'b0, 3'd0);

        // Sprite 3 at the right edge must not wrap to column 0
        spr_x[39:30] = 10'd1010; spr_y[39:30] = 10'd0; spr_en = 4'b1111;
        load_frame();
        px("nowrap",  10'd5,    10'd0, 1'b1, 1'b0, 12'h000, 12'hB83, 1'b0, 3'd0);
        px("edge3",   10'd1015, 10'd0, 1'b1, 1'b0, 12'hC05, 12'h1EB, 1'b1, 3'd3);
        px("invalid", 10'd1015, 10'd0, 1'b0, 1'b0, 12'hC05, 12'h000, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
